// File: rtl/muldiv_hilo_ctrl_pkg.sv
// Shared types and helpers for the HI/LO multiply/divide controller.
package muldiv_hilo_ctrl_pkg;

    typedef logic        i1;
    typedef logic [31:0] i32;
    typedef logic [63:0] i64;

    // HI/LO-class instruction encoding presented by the EX stage.
    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } muldiv_op_t;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_MUL       = 3'd1,
        S_DIV_START = 3'd2,
        S_DIV_RUN   = 3'd3,
        S_DIV_FIX   = 3'd4,
        S_DRAIN     = 3'd5
    } muldiv_state_t;

    // Two's-complement negation, modulo 2^32.
    function automatic i32 neg32(input i32 x);
        return ~x + 32'd1;
    endfunction

    // Magnitude of a signed operand; unsigned operands pass through untouched.
    function automatic i32 abs32(input i32 x, input i1 is_signed);
        return (is_signed && x[31]) ? neg32(x) : x;
    endfunction

endpackage

// File: rtl/Div.sv
// 32-bit unsigned restoring divider, one quotient bit per clock.
// o_done pulses one cycle after the last iteration; o_c = {rem, quo} then
// stays stable until the next launch.
module Div (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_valid,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_done,
    output logic [63:0] o_c
);
    logic        r_busy;
    logic [4:0]  r_cnt;
    logic [31:0] r_quo;
    logic [31:0] r_rem;
    logic [31:0] r_b;
    logic        r_done;

    logic [32:0] w_shift;
    logic        w_ge;
    logic [31:0] w_diff;

    // Shift the next dividend bit into the partial remainder and trial-subtract.
    // When w_ge holds the true difference is below 2^32, so 32 bits suffice.
    assign w_shift = {r_rem, r_quo[31]};
    assign w_ge    = (w_shift >= {1'b0, r_b});
    assign w_diff  = w_shift[31:0] - r_b;

    // Launch on i_valid when idle, then iterate 32 times and pulse done.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (!resetn) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_quo  <= '0;
            r_rem  <= '0;
            r_b    <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!r_busy) begin
                if (i_valid) begin
                    r_busy <= 1'b1;
                    r_cnt  <= '0;
                    r_quo  <= i_a;
                    r_rem  <= '0;
                    r_b    <= i_b;
                end
            end else begin
                r_quo <= {r_quo[30:0], w_ge};
                r_rem <= w_ge ? w_diff : w_shift[31:0];
                r_cnt <= r_cnt + 5'd1;
                if (r_cnt == 5'd31) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_done = r_done;
    assign o_c    = {r_rem, r_quo};

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// EX-stage controller for MULT/MULTU/DIV/DIVU/MTHI/MTLO and owner of HI/LO.
// Multiplies take one stall cycle; divides run on the iterative Div and get
// their sign fixed on the way into HI/LO.
module muldiv_hilo_ctrl
    import muldiv_hilo_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    muldiv_state_t r_state;
    muldiv_state_t w_next;

    i32 r_hi;
    i32 r_lo;
    i64 r_prod;
    i32 r_div_a;
    i32 r_div_b;
    i1  r_sa;
    i1  r_sb;

    muldiv_op_t w_op;
    i1          w_go;
    i1          w_is_div_signed;
    i64         w_prod_s;
    i64         w_prod_u;
    i32         w_quo;
    i32         w_rem;

    i1          w_busy;
    i1          w_div_valid;
    i1          w_div_done;
    i64         w_div_c;

    assign w_op            = muldiv_op_t'(req_op);
    assign w_go            = req_valid & ~flush;
    assign w_is_div_signed = (w_op == OP_DIV);

    // 64x64 products truncated to 64 bits give the exact 32x32 results.
    assign w_prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
    assign w_prod_u = {32'd0, src_a} * {32'd0, src_b};

    assign w_rem = w_div_c[63:32];
    assign w_quo = w_div_c[31:0];

    Div u_div (
        .clk     (clk),
        .resetn  (resetn),
        .i_valid (w_div_valid),
        .i_a     (r_div_a),
        .i_b     (r_div_b),
        .o_done  (w_div_done),
        .o_c     (w_div_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Next-state logic.  Div never raises done in the cycle right after a
    // launch, so DIV_RUN can trust div_done from its first cycle.
    always_comb begin
        // NOTE: default first, so no path through the case leaves w_next
        // unassigned and no latch is inferred.
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_go) begin
                    case (w_op)
                        OP_MULT, OP_MULTU: w_next = S_MUL;
                        OP_DIV,  OP_DIVU:  w_next = S_DIV_START;
                        default:           w_next = S_IDLE;
                    endcase
                end
            end
            S_MUL:       w_next = S_IDLE;
            S_DIV_START: w_next = flush ? S_DRAIN : S_DIV_RUN;
            S_DIV_RUN: begin
                if (flush)           w_next = w_div_done ? S_IDLE : S_DRAIN;
                else if (w_div_done) w_next = S_DIV_FIX;
            end
            S_DIV_FIX:   w_next = S_IDLE;
            S_DRAIN:     if (w_div_done) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    // Stall and divider launch.  MUL and DIV_FIX do not stall: EX retires on
    // the same edge that writes HI/LO.
    always_comb begin
        w_busy      = 1'b0;
        w_div_valid = 1'b0;
        case (r_state)
            S_IDLE:      w_busy = w_go && (w_op == OP_MULT || w_op == OP_MULTU ||
                                           w_op == OP_DIV  || w_op == OP_DIVU);
            S_DIV_START: begin
                w_busy      = 1'b1;
                w_div_valid = 1'b1;
            end
            S_DIV_RUN,
            S_DRAIN:     w_busy = 1'b1;
            default:     w_busy = 1'b0;
        endcase
    end

    // HI/LO, product and divide operand registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_hi    <= '0;
            r_lo    <= '0;
            r_prod  <= '0;
            r_div_a <= '0;
            r_div_b <= '0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        case (w_op)
                            OP_MTHI:  r_hi   <= src_a;
                            OP_MTLO:  r_lo   <= src_a;
                            OP_MULT:  r_prod <= w_prod_s;
                            OP_MULTU: r_prod <= w_prod_u;
                            OP_DIV, OP_DIVU: begin
                                r_div_a <= abs32(src_a, w_is_div_signed);
                                r_div_b <= abs32(src_b, w_is_div_signed);
                                r_sa    <= src_a[31] & w_is_div_signed;
                                r_sb    <= src_b[31] & w_is_div_signed;
                            end
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (!flush) {r_hi, r_lo} <= r_prod;
                end
                S_DIV_FIX: begin
                    // Quotient sign follows sa^sb, remainder follows the dividend.
                    if (!flush) begin
                        r_lo <= (r_sa ^ r_sb) ? neg32(w_quo) : w_quo;
                        r_hi <= r_sa ? neg32(w_rem) : w_rem;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = w_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Self-checking bench for muldiv_hilo_ctrl: expected HI/LO pairs are queued
// when an instruction is issued and compared once it retires.
module tb_muldiv_hilo_ctrl;
    import muldiv_hilo_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    int          checks = 0;
    int          errors = 0;

    localparam int MAX_STALL = 100;

    muldiv_hilo_ctrl dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_op    (req_op),
        .src_a     (src_a),
        .src_b     (src_b),
        .flush     (flush),
        .busy      (busy),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Pop the oldest expectation and compare it with HI/LO.
    task automatic sb_compare(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            checks++;
            if (hi !== e.hi) begin
                errors++;
                $display("FAIL %s hi: got %08h required %08h", name, hi, e.hi);
            end
            checks++;
            if (lo !== e.lo) begin
                errors++;
                $display("FAIL %s lo: got %08h required %08h", name, lo, e.lo);
            end
        end
    endtask

    // Issue one instruction at a negedge, hold it while busy, retire it,
    // then compare HI/LO. Returns the number of stall cycles seen.
    task automatic run_op(input string name, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          output int stalls);
        exp_t e;
        e.hi = exp_hi; e.lo = exp_lo;
        sb.push_back(e);
        m_hi = exp_hi; m_lo = exp_lo;
        req_valid = 1'b1; req_op = op; src_a = a; src_b = b;
        #1;
        stalls = 0;
        while (busy === 1'b1 && stalls < MAX_STALL) begin
            stalls++;
            @(negedge clk);
        end
        if (stalls >= MAX_STALL) begin
            checks++; errors++;
            $display("FAIL %s timeout: busy still high after %0d cycles, required low", name, stalls);
        end
        @(negedge clk);
        req_valid = 1'b0; req_op = OP_NONE;
        #1;
        sb_compare(name);
    endtask

    task automatic test_reset();
        resetn = 1'b0; req_valid = 1'b0; req_op = OP_NONE;
        src_a = '0; src_b = '0; flush = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (hi !== 32'h0)  begin errors++; $display("FAIL reset hi: got %08h required 00000000", hi); end
        checks++; if (lo !== 32'h0)  begin errors++; $display("FAIL reset lo: got %08h required 00000000", lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b required 0", busy); end
        resetn = 1'b1;
        m_hi = '0; m_lo = '0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle busy: got %b required 0", busy); end
    endtask

    task automatic test_mthi_mtlo();
        int st;
        run_op("mthi", OP_MTHI, 32'h12345678, 32'h0, 32'h12345678, m_lo, st);
        checks++; if (st !== 0) begin errors++; $display("FAIL mthi stall: got %0d required 0", st); end
        run_op("mtlo", OP_MTLO, 32'hCAFEF00D, 32'h0, m_hi, 32'hCAFEF00D, st);
        checks++; if (st !== 0) begin errors++; $display("FAIL mtlo stall: got %0d required 0", st); end
    endtask

    task automatic test_mult();
        int st;
        run_op("mult -3*7", OP_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, st);
        checks++; if (st !== 1) begin errors++; $display("FAIL mult stall: got %0d required 1", st); end
        run_op("multu ffffffff*2", OP_MULTU, 32'hFFFFFFFF, 32'd2, 32'h1, 32'hFFFFFFFE, st);
        checks++; if (st !== 1) begin errors++; $display("FAIL multu stall: got %0d required 1", st); end
        run_op("mult ffffffff*2", OP_MULT, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, st);
    endtask

    task automatic test_div();
        int st;
        run_op("div -7/2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, st);
        checks++; if (st < 3 || st > 36) begin errors++; $display("FAIL div stall: got %0d required 3..36", st); end
        run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, st);
        checks++; if (st < 3 || st > 36) begin errors++; $display("FAIL divu stall: got %0d required 3..36", st); end
        run_op("div 7/-2", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, st);
        run_op("divu 7/0", OP_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, st);
        run_op("div min/-1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, st);
        run_op("divu big", OP_DIVU, 32'hFFFFFFFF, 32'h00010000, 32'h0000FFFF, 32'h0000FFFF, st);
    endtask

    task automatic test_flush_mul();
        exp_t e;
        e.hi = m_hi; e.lo = m_lo;
        sb.push_back(e);
        req_valid = 1'b1; req_op = OP_MULT; src_a = 32'd5; src_b = 32'd5;
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_mul busy: got %b required 1", busy); end
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0; req_op = OP_NONE;
        #1;
        sb_compare("flush_mul unchanged");
    endtask

    task automatic test_flush_div_back_to_back();
        exp_t e;
        int   drain;
        int   st;
        e.hi = m_hi; e.lo = m_lo;
        sb.push_back(e);
        req_valid = 1'b1; req_op = OP_DIV; src_a = 32'd100; src_b = 32'hFFFFFFF9;
        #1;
        // IDLE, DIV_START and DIV_RUN cycles 1..4 all stall.
        for (int k = 1; k <= 6; k++) begin
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL flush_div busy cycle %0d: got %b required 1", k, busy); end
            @(negedge clk);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0; req_op = OP_NONE;
        #1;
        drain = 0;
        while (busy === 1'b1 && drain < MAX_STALL) begin
            drain++;
            @(negedge clk);
        end
        checks++;
        if (drain < 20 || drain >= MAX_STALL) begin
            errors++;
            $display("FAIL flush_div drain cycles: got %0d required 20..%0d", drain, MAX_STALL - 1);
        end
        sb_compare("flush_div unchanged");
        run_op("divu 9/4 after drain", OP_DIVU, 32'd9, 32'd4, 32'd1, 32'd2, st);
    endtask

    task automatic test_reset_mid_div();
        int st;
        req_valid = 1'b1; req_op = OP_DIVU; src_a = 32'hFFFFFFFF; src_b = 32'd3;
        repeat (10) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_div busy: got %b required 1", busy); end
        resetn = 1'b0; req_valid = 1'b0; req_op = OP_NONE;
        @(negedge clk);
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL mid_reset busy: got %b required 0", busy); end
        checks++; if (hi !== 32'h0)   begin errors++; $display("FAIL mid_reset hi: got %08h required 00000000", hi); end
        checks++; if (lo !== 32'h0)   begin errors++; $display("FAIL mid_reset lo: got %08h required 00000000", lo); end
        resetn = 1'b1;
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        run_op("divu 20/3 after reset", OP_DIVU, 32'd20, 32'd3, 32'd2, 32'd6, st);
    endtask

    initial begin
        resetn = 1'b0; req_valid = 1'b0; req_op = OP_NONE;
        src_a = '0; src_b = '0; flush = 1'b0;
        @(negedge clk);
        test_reset();
        test_mthi_mtlo();
        test_mult();
        test_div();
        test_flush_mul();
        test_flush_div_back_to_back();
        test_reset_mid_div();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
